mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
Initiator for the single-port 16x16 memory interface. It accepts write/read requests on a valid/ready command port and drives the memory's EN/wr_en/rd_en/add/Data_in strobes. It waits for valid_out and returns read data or an error on a valid/ready response port. It is the pin-level driver between system logic and the memory block.

Parameters:
ADDR_W, 4, address width (16 locations)
DATA_W, 32, data word width
TIMEOUT, 15, maximum wait cycles for mem_valid_out after a read strobe

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_wr  in  1  1 = write, 0 = read
req_add  in  ADDR_W  request address
req_data  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_data  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  timeout or verify error
busy  out  1  high in any state other than IDLE
mem_EN  out  1  memory enable strobe
mem_wr_en  out  1  memory write strobe
mem_rd_en  out  1  memory read strobe
mem_add  out  ADDR_W  memory address
mem_Data_in  out  DATA_W  memory write data
mem_valid_out  in  1  memory read data valid
mem_Data_out  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, async): every output is 0, FSM goes to IDLE, timeout counter is 0, and any pending transaction is discarded with no response. After release, req_ready=1 from the first clock edge.
- FSM states: IDLE, WR, RD, RD_WAIT, RESP (plus VFY_RD/VFY_WAIT under the option).
- IDLE: req_ready=1. On handshake, register req_wr, req_add and req_data, then go to WR if req_wr=1, else RD.
- Outside IDLE: req_ready=0. New requests are ignored until the FSM returns to IDLE.
- WR (1 cycle): mem_EN=1, mem_wr_en=1, mem_add and mem_Data_in come from the captured request. Next state is RESP with rsp_data=0 and rsp_err=0.
- RD (1 cycle): mem_EN=1, mem_rd_en=1, mem_add from the captured request. Next state is RD_WAIT and the counter clears.
- RD_WAIT:
  - mem_valid_out=1: capture mem_Data_out into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no valid_out: rsp_data=0, rsp_err=1, go to RESP.
  - Counter width is $clog2(TIMEOUT+1).
- mem_valid_out is ignored in every state except RD_WAIT (and VFY_WAIT). This includes the strobe cycle itself.
- RESP: rsp_valid=1. rsp_data and rsp_err are registered and held stable until rsp_ready=1. On handshake, go to IDLE, so req_ready=1 in the next cycle.
- Strobe rules:
  - mem_EN, mem_wr_en and mem_rd_en are registered outputs and high for exactly one cycle per access.
  - mem_wr_en and mem_rd_en are never high together.
  - mem_add and mem_Data_in are 0 whenever mem_EN=0.
- Latency (handshake in cycle N, rsp_ready held 1):
  - write: strobe in N+1, rsp_valid in N+2.
  - read with valid_out in N+2: rsp_valid in N+3.
- Throughput: at most one outstanding transaction; no pipelining.

Optional Feature:
WR_VERIFY_EN
- Defined: after WR, the FSM enters VFY_RD. It issues a one-cycle read strobe to the same address, then enters VFY_WAIT, which times out exactly like RD_WAIT.
  - On valid_out, mem_Data_out is compared with the written data. Mismatch gives rsp_err=1 with rsp_data = the read value. Match gives rsp_err=0 and rsp_data=0.
  - Timeout gives rsp_err=1 and rsp_data=0.
  - Write latency becomes N+4 minimum.
- Undefined: the VFY states and the comparator are not compiled. The write response follows WR directly, as above.

Test Plan:
1. Assert rst=0 in the middle of RD_WAIT -> all outputs 0 immediately, with no clock needed. After release, req_ready=1 and busy=0, and no rsp_valid is ever issued for the aborted read.
2. Write add=4, data=0xDEADBEEF, handshake in cycle N -> in N+1, mem_EN=1, mem_wr_en=1, mem_add=4, mem_Data_in=0xDEADBEEF for exactly one cycle. In N+2, rsp_valid=1, rsp_err=0, rsp_data=0.
3. Read add=4 with the model returning valid_out and 0xDEADBEEF one cycle after the strobe -> mem_rd_en pulses in N+1. In N+3, rsp_data=0xDEADBEEF and rsp_err=0.
4. Read add=15 with the model never asserting valid_out -> after 15 RD_WAIT cycles, rsp_valid=1, rsp_err=1, rsp_data=0.
5. Hold rsp_ready=0 for 5 cycles after a read response while req_valid=1 -> rsp_valid, rsp_data and rsp_err stay stable, req_ready=0, and there are no memory strobes. The next request is accepted the cycle after rsp_ready=1.
6. Under WR_VERIFY_EN, have the model corrupt the readback: write 0x12345678, model returns 0x12345679 -> rsp_err=1 and rsp_data=0x12345679.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: valid/ready initiator driving the 16x16 single-port memory.
// Define WR_VERIFY_EN to read back and compare every write.
module mem_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_add,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_EN,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_Data_in,
  input  logic              mem_valid_out,
  input  logic [DATA_W-1:0] mem_Data_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RESP
`ifdef WR_VERIFY_EN
    ,
    VFY_RD,
    VFY_WAIT
`endif
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_q       <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_add_q   <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_q       <= add_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_add_q   <= mem_add_d;
      mem_din_q   <= mem_din_d;
    end
  end

  // req_ready_q gates the capture so nothing is taken before the first edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    add_d   = add_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          add_d   = req_add;
          data_d  = req_data;
          state_d = req_wr ? WR : RD;
        end
      end
      WR: begin
`ifdef WR_VERIFY_EN
        state_d = VFY_RD;
`else
        state_d = RESP;
`endif
      end
      RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_valid_out) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = RESP;
        end
      end
`ifdef WR_VERIFY_EN
      VFY_RD: begin
        cnt_d   = '0;
        state_d = VFY_WAIT;
      end
      VFY_WAIT: begin
        if (mem_valid_out) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = RESP;
        end
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin leaves a flop
  always_comb begin
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_wr_d    = (state_d == WR);
`ifdef WR_VERIFY_EN
    mem_rd_d    = (state_d == RD) || (state_d == VFY_RD);
`else
    mem_rd_d    = (state_d == RD);
`endif
    mem_en_d    = mem_wr_d | mem_rd_d;
    mem_add_d   = mem_en_d ? add_d : '0;
    mem_din_d   = mem_wr_d ? data_d : '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (state_d == IDLE) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
    end else if (state_d == RESP && state_q != RESP) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      unique case (state_q)
        RD_WAIT: begin
          if (mem_valid_out) rsp_data_d = mem_Data_out;
          else rsp_err_d = 1'b1;
        end
`ifdef WR_VERIFY_EN
        VFY_WAIT: begin
          if (!mem_valid_out) begin
            rsp_err_d = 1'b1;
          end else if (mem_Data_out != data_q) begin
            rsp_data_d = mem_Data_out;
            rsp_err_d  = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_EN      = mem_en_q;
  assign mem_wr_en   = mem_wr_q;
  assign mem_rd_en   = mem_rd_q;
  assign mem_add     = mem_add_q;
  assign mem_Data_in = mem_din_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: random requests against a memory model, scoreboarded.
// Response expectations come from a per-request rule model, not the FSM.
module tb_mem_master;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_add = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mem_EN;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [3:0]  mem_add;
  logic [31:0] mem_Data_in;
  logic        mem_valid_out = 1'b0;
  logic [31:0] mem_Data_out = '0;

  mem_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_add(req_add), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mem_EN(mem_EN), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_add(mem_add), .mem_Data_in(mem_Data_in),
    .mem_valid_out(mem_valid_out), .mem_Data_out(mem_Data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [3:0]  add;
    logic [31:0] data;
  } stb_t;

  rsp_t        exp_q[$];
  stb_t        stb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ref_mem[16];
  logic [31:0] mem_arr[16];
  int          cfg_delay = 0;
  bit          cfg_junk = 0;
  bit          cfg_corrupt = 0;
  int          rd_delay = 0;
  logic [31:0] rd_val = '0;
  int          hold_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Memory model: strobe checker, storage and delayed read return
  always @(negedge clk) begin
    logic bad;
    stb_t s;
    mem_valid_out = 1'b0;
    mem_Data_out  = $urandom;
    if (!rst) rd_delay = 0;
    if (rd_delay > 0) begin
      rd_delay--;
      if (rd_delay == 0) begin
        mem_valid_out = 1'b1;
        mem_Data_out  = rd_val;
      end
    end
    if (rst) begin
      bad = (mem_wr_en & mem_rd_en) |
            (mem_EN != (mem_wr_en | mem_rd_en)) |
            (!mem_EN && (mem_add != 0 || mem_Data_in != 0));
      chk("strobe_rules", bad, 0);
    end
    if (rst && mem_EN) begin
      if (stb_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        s = stb_q.pop_front();
        chk("strobe_cycle", cyc, s.cyc);
        chk("strobe_kind", mem_wr_en, s.wr);
        chk("strobe_add", mem_add, s.add);
        if (s.wr) chk("strobe_wdata", mem_Data_in, s.data);
      end
      if (mem_wr_en) mem_arr[mem_add] = mem_Data_in;
      if (mem_rd_en) begin
        rd_val   = mem_arr[mem_add] ^ {31'd0, cfg_corrupt};
        rd_delay = cfg_delay;
        if (cfg_junk) begin
          mem_valid_out = 1'b1;
          mem_Data_out  = ~rd_val;
        end
      end
    end
  end

  // Response monitor and scoreboard
  int          hold_seen = 0;
  int          hold_cnt = 0;
  bit          prev_valid = 0;
  bit          after_hs = 0;
  logic [32:0] prev_val = '0;

  always @(negedge clk) begin
    rsp_t e;
    if (hold_req != hold_seen) begin
      hold_seen = hold_req;
      hold_cnt  = 5;
    end
    if (hold_cnt > 0) rsp_ready = 1'b0;
    else rsp_ready = ($urandom % 4) != 0;
    if (rst && after_hs) chk("req_ready_after_rsp", req_ready, 1);
    after_hs = 0;
    if (rst && rsp_valid) begin
      chk("resp_quiet", {req_ready, mem_EN, busy}, 3'b001);
      if (!prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else chk("rsp_latency", cyc, exp_q[0].cyc);
      end else begin
        chk("rsp_stable", {rsp_data, rsp_err}, prev_val);
      end
      if (hold_cnt > 0) hold_cnt--;
      if (rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        after_hs = 1;
      end
    end
    prev_valid = rst && rsp_valid;
    prev_val   = {rsp_data, rsp_err};
  end

  // delay: 0 = memory never answers, else cycles from strobe to valid_out
  task automatic issue(bit wr, logic [3:0] a, logic [31:0] d,
                       int delay, bit junk, bit corrupt);
    int   n;
    int   t;
    bit   ok;
    rsp_t e;
    stb_t s;
    req_valid = 1'b1;
    req_wr    = wr;
    req_add   = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    t           = cyc;
    cfg_delay   = delay;
    cfg_junk    = junk;
    cfg_corrupt = wr && corrupt;
    ok          = delay >= 1 && delay <= TMO;
    s.cyc = t + 1;
    s.wr  = wr;
    s.add = a;
    s.data = d;
    stb_q.push_back(s);
    if (wr) begin
      ref_mem[a] = d;
`ifdef WR_VERIFY_EN
      s.cyc = t + 2;
      s.wr  = 1'b0;
      stb_q.push_back(s);
      e.cyc  = ok ? t + 3 + delay : t + 3 + TMO;
      e.err  = !ok || corrupt;
      e.data = (ok && corrupt) ? (d ^ 32'd1) : 32'd0;
`else
      e.cyc  = t + 2;
      e.err  = 1'b0;
      e.data = 32'd0;
`endif
    end else begin
      e.cyc  = ok ? t + 2 + delay : t + 2 + TMO;
      e.err  = !ok;
      e.data = ok ? ref_mem[a] : 32'd0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_add   = 4'($urandom);
    req_data  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      mem_arr[i] = v;
    end
    #1;
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_data, rsp_err, busy, mem_EN,
         mem_wr_en, mem_rd_en, mem_add, mem_Data_in}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_reset", {req_ready, busy}, 2'b10);
    @(negedge clk);

    issue(1, 4'd4, 32'hDEADBEEF, 1, 0, 0);
    issue(0, 4'd4, 32'h0, 1, 0, 0);
    issue(0, 4'd15, 32'h0, 0, 1, 0);
    hold_req++;
    issue(0, 4'd4, 32'h0, 3, 0, 0);
    issue(1, 4'd2, 32'hA5A5_0F0F, 2, 0, 0);
`ifdef WR_VERIFY_EN
    issue(1, 4'd9, 32'h12345678, 2, 0, 1);
    issue(1, 4'd10, 32'h0BADF00D, 0, 0, 0);
`endif
    issue(0, 4'd2, 32'h0, TMO, 1, 0);
    issue(0, 4'd2, 32'h0, TMO + 1, 0, 0);
    drain();

    // Abort a read in the middle of its wait
    issue(0, 4'd7, 32'h0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        {req_ready, rsp_valid, rsp_data, rsp_err, busy, mem_EN,
         mem_wr_en, mem_rd_en, mem_add, mem_Data_in}, 0);
    exp_q.delete();
    stb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_abort", {req_ready, busy}, 2'b10);
    repeat (25) @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      int r;
      int dl;
      r = $urandom % 10;
      if (r == 0) dl = 0;
      else if (r == 1) dl = TMO + 1;
      else if (r == 2) dl = TMO;
      else dl = $urandom_range(1, 6);
      issue(1'($urandom), 4'($urandom), $urandom, dl,
            1'($urandom), ($urandom % 4) == 0);
    end
    drain();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
